// File: rtl/count_sequencer.sv
// count_sequencer: run-control sequencer for the two-digit BCD counter path.
// Turns start/stop/clear buttons into an IDLE/RUN/PAUSE/DONE Moore FSM,
// divides clk down to the count tick, owns the BCD units/tens registers and
// produces the blank strobe for the terminal alarm blink.
// Optional feature: define DEBOUNCE_EN to insert a per-button debouncer
// between the synchronizer and the edge detector.
module count_sequencer #(
  parameter int TICK_DIV   = 50,
  parameter int BLINK_DIV  = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  input  logic       dir_up,
  input  logic       wrap_en,
  input  logic       load_en,
  input  logic [3:0] load_dec,
  input  logic [3:0] load_uni,
  output logic [3:0] dec,
  output logic [3:0] uni,
  output logic       blank,
  output logic       running,
  output logic       done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  // Button vector order: bit 0 start, bit 1 stop, bit 2 clear.
  logic [2:0] w_btn;
  logic [2:0] w_level;
  logic [2:0] r_sync1, r_sync2, r_prev, r_pulse;

  assign w_btn = {btn_clear, btn_stop, btn_start};

  // Two-flop synchronizer for the asynchronous buttons.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two sync stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [2:0]       r_acc;
  logic [DEB_W-1:0] r_deb_cnt [3];

  // Debouncer: accept a new level after DEB_CYCLES consecutive differing samples.
  // NOTE: this counter array is reset explicitly; unlike RAM-style storage it is
  // a handful of flops whose stale values would otherwise fire spurious pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_acc[i]) begin
          if (r_deb_cnt[i] == DEB_LAST) begin
            r_acc[i]     <= r_sync2[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_level = r_acc;
`else
  localparam int deb_cycles_unused = DEB_CYCLES;
  assign w_level = r_sync2;
`endif

  // Registered rising-edge detect: one-cycle pulse per accepted press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= '0;
      r_pulse <= '0;
    end else begin
      r_prev  <= w_level;
      r_pulse <= w_level & ~r_prev;
    end
  end

  logic w_start, w_stop, w_clr;
  assign w_start = r_pulse[0];
  assign w_stop  = r_pulse[1];
  assign w_clr   = r_pulse[2];

  logic [1:0]       r_state, w_state_nx;
  logic [DIV_W-1:0] r_div;
  logic [BLK_W-1:0] r_blk_cnt;
  logic [3:0]       r_dec, r_uni;
  logic             r_blank;
  logic             w_tick;
  logic [3:0]       w_nx_dec, w_nx_uni, w_ld_dec, w_ld_uni;
  logic             w_at_term;

  // The divider only advances in RUN and DONE, so the tick is gated the same way.
  assign w_tick = ((r_state == RUN) || (r_state == DONE)) && (r_div == DIV_LAST);

  assign w_ld_dec = (load_dec > 4'd9) ? 4'd9 : load_dec;
  assign w_ld_uni = (load_uni > 4'd9) ? 4'd9 : load_uni;

  // BCD step in the currently selected direction, always wrapping arithmetically.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_nx_dec = r_dec;
    w_nx_uni = r_uni;
    if (dir_up) begin
      if (r_uni == 4'd9) begin
        w_nx_uni = 4'd0;
        w_nx_dec = (r_dec == 4'd9) ? 4'd0 : r_dec + 4'd1;
      end else begin
        w_nx_uni = r_uni + 4'd1;
      end
    end else begin
      if (r_uni == 4'd0) begin
        w_nx_uni = 4'd9;
        w_nx_dec = (r_dec == 4'd0) ? 4'd9 : r_dec - 4'd1;
      end else begin
        w_nx_uni = r_uni - 4'd1;
      end
    end
    // Terminal is judged on the landing value, so starting at 99/00 steps away.
    w_at_term = dir_up ? ((w_nx_dec == 4'd9) && (w_nx_uni == 4'd9))
                       : ((w_nx_dec == 4'd0) && (w_nx_uni == 4'd0));
  end

  // Next-state logic with pulse priority clear > stop > start.
  always_comb begin
    w_state_nx = r_state;
    if (w_clr) begin
      w_state_nx = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (!w_stop && w_start) w_state_nx = RUN;
        RUN: begin
          if (w_stop)                           w_state_nx = PAUSE;
          else if (w_tick && !wrap_en && w_at_term) w_state_nx = DONE;
        end
        PAUSE:   if (!w_stop && w_start) w_state_nx = RUN;
        DONE:    w_state_nx = DONE;
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Tick divider: restarts on IDLE->RUN, holds in PAUSE to keep tick phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_clr || ((r_state == IDLE) && (w_state_nx == RUN))) begin
      r_div <= '0;
    end else if ((r_state == RUN) || (r_state == DONE)) begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
    end
  end

  // Count registers: step on tick in RUN, preset load only in IDLE/PAUSE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec <= '0;
      r_uni <= '0;
    end else if (w_clr) begin
      r_dec <= '0;
      r_uni <= '0;
    end else if ((r_state == RUN) && w_tick) begin
      r_dec <= w_nx_dec;
      r_uni <= w_nx_uni;
    end else if (load_en && ((r_state == IDLE) || (r_state == PAUSE))) begin
      r_dec <= w_ld_dec;
      r_uni <= w_ld_uni;
    end
  end

  // Alarm blink: toggle blank every BLINK_DIV ticks while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt <= '0;
      r_blank   <= 1'b0;
    end else if (w_clr) begin
      r_blk_cnt <= '0;
      r_blank   <= 1'b0;
    end else if ((r_state == DONE) && w_tick) begin
      if (r_blk_cnt == BLK_LAST) begin
        r_blk_cnt <= '0;
        r_blank   <= ~r_blank;
      end else begin
        r_blk_cnt <= r_blk_cnt + BLK_W'(1);
      end
    end
  end

  assign dec     = r_dec;
  assign uni     = r_uni;
  assign blank   = r_blank;
  assign running = (r_state == RUN);
  assign done    = (r_state == DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed scoreboard bench for count_sequencer.
// Expected display/status tuples are queued as stimulus is applied and popped
// and compared when the DUT is due to show them.
module tb_count_sequencer;

  localparam int TD  = 50;
  localparam int BD  = 4;
  localparam int DEB = 4;
`ifdef DEBOUNCE_EN
  localparam int LAT = 4 + DEB;
`else
  localparam int LAT = 4;
`endif

  logic       clk, rst_n;
  logic       btn_start, btn_stop, btn_clear;
  logic       dir_up, wrap_en, load_en;
  logic [3:0] load_dec, load_uni;
  logic [3:0] dec, uni;
  logic       blank, running, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] d;
    logic [3:0] u;
    logic       r;
    logic       dn;
    logic       b;
  } exp_t;

  exp_t sb[$];

  count_sequencer #(.TICK_DIV(TD), .BLINK_DIV(BD), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_stop(btn_stop), .btn_clear(btn_clear),
    .dir_up(dir_up), .wrap_en(wrap_en), .load_en(load_en),
    .load_dec(load_dec), .load_uni(load_uni),
    .dec(dec), .uni(uni), .blank(blank), .running(running), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [3:0] d, input logic [3:0] u,
                      input logic r, input logic dn, input logic b);
    exp_t e;
    e.tag = tag; e.d = d; e.u = u; e.r = r; e.dn = dn; e.b = b;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [10:0] obs, want;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: got 0 entries required >=1");
      return;
    end
    e    = sb.pop_front();
    obs  = {dec, uni, running, done, blank};
    want = {e.d, e.u, e.r, e.dn, e.b};
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: dec,uni,run,done,blank got %h%h %b%b%b required %h%h %b%b%b",
             e.tag, dec, uni, running, done, blank, e.d, e.u, e.r, e.dn, e.b);
    end
  endtask

  task automatic load(input logic [3:0] d, input logic [3:0] u);
    load_en = 1'b1; load_dec = d; load_uni = u;
    cyc(1);
    load_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    btn_start = 1'b0; btn_stop = 1'b0; btn_clear = 1'b0;
    dir_up = 1'b1; wrap_en = 1'b1; load_en = 1'b0;
    load_dec = 4'd0; load_uni = 4'd0;
    cyc(3);
    push("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); check();
    rst_n = 1'b1;
    cyc(2);

`ifdef DEBOUNCE_EN
    // Short glitch must not be accepted.
    btn_start = 1'b1; cyc(2); btn_start = 1'b0;
    cyc(12);
    push("glitch_ignored", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); check();
`endif

    // Start latency, first tick after TICK_DIV cycles, 09->10 carry.
    btn_start = 1'b1;
    cyc(LAT - 1);
    push("start_not_yet", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); check();
    cyc(1);
    btn_start = 1'b0;
    push("start_run", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0); check();
    cyc(TD - 1);
    push("before_first_tick", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0); check();
    cyc(1);
    push("first_tick", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0); check();
    cyc(8 * TD);
    push("count_09", 4'd0, 4'd9, 1'b1, 1'b0, 1'b0); check();
    cyc(TD);
    push("carry_10", 4'd1, 4'd0, 1'b1, 1'b0, 1'b0); check();

    // Load ignored in RUN; stop lands the divider at 20 in PAUSE.
    load(4'd5, 4'd5);
    push("load_in_run_ignored", 4'd1, 4'd0, 1'b1, 1'b0, 1'b0); check();
    cyc(19 - LAT);
    btn_stop = 1'b1; cyc(LAT); btn_stop = 1'b0;
    push("pause", 4'd1, 4'd0, 1'b0, 1'b0, 1'b0); check();
    cyc(200);
    push("pause_frozen", 4'd1, 4'd0, 1'b0, 1'b0, 1'b0); check();

    // Resume keeps phase: next step 30 cycles after resume edge.
    btn_start = 1'b1; cyc(LAT); btn_start = 1'b0;
    push("resume", 4'd1, 4'd0, 1'b1, 1'b0, 1'b0); check();
    cyc(TD - 20 - 1);
    push("resume_before_tick", 4'd1, 4'd0, 1'b1, 1'b0, 1'b0); check();
    cyc(1);
    push("resume_tick", 4'd1, 4'd1, 1'b1, 1'b0, 1'b0); check();

    // clear + stop in RUN: clear wins.
    btn_clear = 1'b1; btn_stop = 1'b1; cyc(LAT);
    btn_clear = 1'b0; btn_stop = 1'b0;
    push("clear_over_stop", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); check();
    cyc(12);

    // start + stop in IDLE: stop wins and is ignored.
    btn_start = 1'b1; btn_stop = 1'b1; cyc(LAT);
    btn_start = 1'b0; btn_stop = 1'b0;
    push("start_stop_idle", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); check();
    cyc(12);

    // One-shot up from 97, then blink and clear.
    load(4'd9, 4'd7);
    push("load_97", 4'd9, 4'd7, 1'b0, 1'b0, 1'b0); check();
    wrap_en = 1'b0; dir_up = 1'b1;
    push("oneshot_run", 4'd9, 4'd7, 1'b1, 1'b0, 1'b0);
    push("oneshot_98",  4'd9, 4'd8, 1'b1, 1'b0, 1'b0);
    push("oneshot_99",  4'd9, 4'd9, 1'b0, 1'b1, 1'b0);
    btn_start = 1'b1; cyc(LAT); btn_start = 1'b0;
    check();
    cyc(TD); check();
    cyc(TD); check();
    cyc(BD * TD - 1);
    push("blank_not_yet", 4'd9, 4'd9, 1'b0, 1'b1, 1'b0); check();
    cyc(1);
    push("blank_on", 4'd9, 4'd9, 1'b0, 1'b1, 1'b1); check();
    cyc(BD * TD);
    push("blank_off", 4'd9, 4'd9, 1'b0, 1'b1, 1'b0); check();
    btn_start = 1'b1; cyc(LAT); btn_start = 1'b0;
    push("start_in_done_ignored", 4'd9, 4'd9, 1'b0, 1'b1, 1'b0); check();
    btn_clear = 1'b1; cyc(LAT); btn_clear = 1'b0;
    push("clear_from_done", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); check();
    cyc(12);

    // Down count with wrap: 01 -> 00 -> 99, never DONE.
    load(4'd0, 4'd1);
    push("load_01", 4'd0, 4'd1, 1'b0, 1'b0, 1'b0); check();
    dir_up = 1'b0; wrap_en = 1'b1;
    btn_start = 1'b1; cyc(LAT); btn_start = 1'b0;
    push("down_run", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0); check();
    cyc(TD);
    push("down_00", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0); check();
    cyc(TD);
    push("down_wrap_99", 4'd9, 4'd9, 1'b1, 1'b0, 1'b0); check();
    btn_clear = 1'b1; cyc(LAT); btn_clear = 1'b0;
    push("clear_in_run", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); check();
    cyc(12);
    load(4'd12, 4'd15);
    push("load_clamped_99", 4'd9, 4'd9, 1'b0, 1'b0, 1'b0); check();

    // Start at terminal with wrap off: steps away, no DONE; dir change next tick.
    dir_up = 1'b1; wrap_en = 1'b0;
    btn_start = 1'b1; cyc(LAT); btn_start = 1'b0;
    push("terminal_start_run", 4'd9, 4'd9, 1'b1, 1'b0, 1'b0); check();
    cyc(TD);
    push("terminal_up_wraps_00", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0); check();
    dir_up = 1'b0;
    cyc(TD);
    push("dir_change_99", 4'd9, 4'd9, 1'b1, 1'b0, 1'b0); check();

    // Stop coincident with tick: step applied and PAUSE.
    cyc(TD - LAT);
    btn_stop = 1'b1; cyc(LAT); btn_stop = 1'b0;
    push("stop_with_tick", 4'd9, 4'd8, 1'b0, 1'b0, 1'b0); check();
    load(4'd4, 4'd5);
    push("load_in_pause", 4'd4, 4'd5, 1'b0, 1'b0, 1'b0); check();

    // Asynchronous reset mid-RUN clears outputs without a clock edge.
    btn_start = 1'b1; cyc(LAT); btn_start = 1'b0;
    push("run_before_reset", 4'd4, 4'd5, 1'b1, 1'b0, 1'b0); check();
    cyc(10);
    #2 rst_n = 1'b0;
    #1;
    push("async_reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); check();
    cyc(2);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Run-control sequencer for the two-digit BCD counter path. It turns start/stop/clear button inputs into a Moore FSM (IDLE/RUN/PAUSE/DONE) and generates the count tick. It owns the BCD units/tens registers, supports up/down counting, preset load and wrap or one-shot terminal behaviour. It drives the digit inputs of the display multiplexer and a blank strobe for the terminal alarm blink.

## Interface
- TICK_DIV, 50: clk cycles per count step while running (≥2).
- BLINK_DIV, 4: count ticks per blank toggle in DONE (≥1).
- DEB_CYCLES, 4: consecutive stable samples needed to accept a button level (used only with debounce compiled in).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- btn_start  in  1  asynchronous button, rising edge = start/resume.
- btn_stop  in  1  asynchronous button, rising edge = pause.
- btn_clear  in  1  asynchronous button, rising edge = clear to 00/IDLE.
- dir_up  in  1  synchronous; 1 = count up, 0 = count down.
- wrap_en  in  1  synchronous; 1 = wrap at terminal, 0 = stop in DONE.
- load_en  in  1  synchronous level; load preset this cycle.
- load_dec  in  4  preset tens digit.
- load_uni  in  4  preset units digit.
- dec  out  4  tens BCD digit to display.
- uni  out  4  units BCD digit to display.
- blank  out  1  1 = display blanked (alarm blink).
- running  out  1  1 in RUN.
- done  out  1  1 in DONE.

## Operation
- Each button passes through a 2-flop synchronizer, then registered rising-edge detect, giving a one-cycle pulse.
- Pulse priority: clear > stop > start.
- **IDLE:** start → RUN. stop is ignored. load_en loads the preset.
- **RUN:** a tick steps the count. stop → PAUSE.
  - If wrap_en=0 and the step lands on the terminal value (99 up, 00 down), go to DONE on that tick; the count shows the terminal value.
- **PAUSE:** start → RUN. load_en loads the preset.
- **DONE:** start and stop are ignored. blank toggles every BLINK_DIV ticks.
- **clear (any state):** → IDLE, dec=uni=0, divider=0, blink counter=0, blank=0.
- **BCD step up:** uni 9→0 with dec+1; 99→00 (wrap case only).
- **BCD step down:** uni 0→9 with dec−1; 00→99 (wrap case only).
- dir_up and wrap_en are sampled at each tick; a change mid-run affects the next step only.
- **Load:** a digit >9 is clamped to 9. load_en in RUN or DONE is ignored. Load and clear in the same cycle: clear wins.
- **Starting in DONE-like position:** start in IDLE with count at the terminal value and wrap_en=0 still enters RUN. The next tick steps away from the terminal (99 down→98) or wraps (99 up→00); it does not re-enter DONE.
- **Outputs:** running=(state==RUN), done=(state==DONE), both registered-state decodes. blank=0 outside DONE.

## Timing
- **Reset values:** state IDLE, dec=0, uni=0, blank=0, running=0, done=0; divider, blink counter and all sync/edge flops 0.
- **Button latency (no debounce):** a button high before edge k gives its pulse after edge k+2. State and outputs change at edge k+3.
- **Divider:**
  - Counts only in RUN and DONE.
  - Holds its value in PAUSE, so resume keeps the tick phase.
  - Reset to 0 on IDLE→RUN and on clear.
  - Tick is asserted when divider==TICK_DIV−1, and the divider returns to 0.
  - The first step after IDLE→RUN occurs exactly TICK_DIV cycles after the transition edge.
- **Load:** takes effect at the same edge where load_en is sampled high; dec/uni update next cycle.
- **Simultaneous events:** a stop pulse and a tick in the same cycle: the step is applied and the state becomes PAUSE.
- **Mid-operation reset:** asynchronous rst_n forces all reset values immediately, independent of clk.

## Configuration
- DEBOUNCE_EN defined:
  - After synchronization, each button feeds a saturating counter.
  - The accepted level changes only after DEB_CYCLES consecutive equal samples that differ from the current accepted level.
  - Edge detect acts on the accepted level.
  - Button latency becomes k+2+DEB_CYCLES.
  - Glitches shorter than DEB_CYCLES cycles produce no pulse.
- DEBOUNCE_EN undefined: synchronizer plus edge detect only. DEB_CYCLES is unused.

## Test plan
- **Reset/start:** release reset, pulse start, dir_up=1, TICK_DIV=50 → running=1 three cycles after start; uni=1 after 50 more cycles; 09→10 carry correct.
- **One-shot up:** load 97 in IDLE, wrap_en=0, start → counts 98, 99, then done=1, count holds 99; blank toggles every 4 ticks; clear → 00, blank=0, IDLE.
- **Down wrap:** load 01, dir_up=0, wrap_en=1, start → 00 then 99, never DONE; load_dec=12, load_uni=15 in IDLE → loads 99 (clamped).
- **Pause/resume phase:** stop at divider=20 → PAUSE, count frozen for 200 cycles; start → next tick 30 cycles after resume takes effect.
- **Priority:** start+stop same cycle in IDLE → stays IDLE; clear+stop in RUN → IDLE 00; stop coincident with tick → step applied, PAUSE.
- **Debounce (DEBOUNCE_EN):** 2-cycle start glitch → no transition; 10-cycle press → RUN at k+2+4+1; rst_n low mid-RUN → all outputs 0 immediately.
